// File: rtl/div_shiftsub.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock, MSB first.
// Optional result self-check built when DIV_SHIFTSUB_CHECK_EN is defined.
module div_shiftsub #(
    parameter int WIDTH_N = 8,
    parameter int WIDTH_D = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] div_a,
    input  logic [WIDTH_D-1:0] div_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] div_q,
    output logic [WIDTH_D-1:0] div_r,
    output logic               div_by_zero,
    output logic               check_err
);

    localparam int CW = $clog2(WIDTH_N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH_N-1:0] r_dvd;
    logic [WIDTH_N-1:0] r_q;
    logic [WIDTH_D-1:0] r_dvs;
    logic [WIDTH_D-1:0] r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_dbz;
    logic [WIDTH_D:0]   w_tmp;
    logic [WIDTH_D-1:0] w_diff;
    logic               w_ge;
    logic               w_accept;
    logic               w_zero;
    logic               w_last;

    assign w_accept = start && (r_state != S_CALC);
    assign w_zero   = (div_b == '0);
    assign w_last   = (r_cnt == CW'(WIDTH_N - 1));

    // The widened partial remainder is below 2*divisor, so the low bits suffice for the difference.
    assign w_tmp  = {r_rem, r_dvd[WIDTH_N-1]};
    assign w_ge   = (w_tmp >= {1'b0, r_dvs});
    assign w_diff = w_tmp[WIDTH_D-1:0] - r_dvs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= div_a;
            r_dvs <= div_b;
            r_rem <= '0;
            r_cnt <= '0;
            r_dbz <= w_zero;
            r_q   <= w_zero ? '1 : '0;
        end else if (r_state == S_CALC) begin
            r_dvd <= r_dvd << 1;
            r_rem <= w_ge ? w_diff : w_tmp[WIDTH_D-1:0];
            r_q   <= {r_q[WIDTH_N-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy        = (r_state == S_CALC);
    assign done        = (r_state == S_DONE);
    assign div_q       = r_q;
    assign div_r       = r_rem;
    assign div_by_zero = r_dbz;

`ifdef DIV_SHIFTSUB_CHECK_EN
    localparam int MW = WIDTH_N + WIDTH_D + 1;

    logic [WIDTH_N-1:0] r_a;
    logic [MW-1:0]      w_mac;
    logic               r_err;

    // The shift register consumes the dividend, so keep a copy to check against.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
        end else if (w_accept) begin
            r_a <= div_a;
        end
    end

    assign w_mac = MW'(r_q) * MW'(r_dvs) + MW'(r_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_DONE && !r_dbz && w_mac != MW'(r_a)) begin
            r_err <= 1'b1;
        end
    end

    assign check_err = r_err;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_shiftsub.sv
// Bench for div_shiftsub: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_div_shiftsub;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] div_a = '0;
    logic [D-1:0] div_b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] div_q;
    logic [D-1:0] div_r;
    logic         div_by_zero;
    logic         check_err;

    int n_checks = 0;
    int n_fail = 0;

    div_shiftsub #(.WIDTH_N(N), .WIDTH_D(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .div_a       (div_a),
        .div_b       (div_b),
        .busy        (busy),
        .done        (done),
        .div_q       (div_q),
        .div_r       (div_r),
        .div_by_zero (div_by_zero),
        .check_err   (check_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts clock edges since the accepted start,
    // m_l is the edge count at which the result appears.
    bit m_active = 1'b0;
    int m_t = 0;
    int m_l = 0;
    int m_q = 0;
    int m_r = 0;
    int m_dbz = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_l      <= 0;
            m_q      <= 0;
            m_r      <= 0;
            m_dbz    <= 0;
        end else if (start && !(m_active && m_t < m_l)) begin
            m_active <= 1'b1;
            m_t      <= 0;
            if (div_b == 0) begin
                m_l   <= 0;
                m_q   <= (1 << N) - 1;
                m_r   <= 0;
                m_dbz <= 1;
            end else begin
                m_l   <= N;
                m_q   <= int'(div_a) / int'(div_b);
                m_r   <= int'(div_a) % int'(div_b);
                m_dbz <= 0;
            end
        end else if (m_active && m_t < 1000) begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        bit eb;
        bit ed;
        eb = m_active && (m_t < m_l);
        ed = m_active && (m_t == m_l);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("check_err", check_err, 0);
        chk("busy_and_done", busy & done, 0);
        if (!m_active || m_t >= m_l) begin
            chk("model_q", div_q, m_q);
            chk("model_r", div_r, m_r);
            chk("model_dbz", div_by_zero, m_dbz);
        end
    end

    // Returns at the negedge of the done cycle; edges counted after the start edge.
    task automatic wait_done(output int edges);
        bit seen;
        edges = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        chk("done_timeout", seen, 1);
    endtask

    task automatic run_op(input int a, input int b, input bit lit,
                          input int e_edges, input int e_q, input int e_r, input int e_dbz);
        int edges;
        @(posedge clk);
        #1;
        start = 1'b1;
        div_a = N'(a);
        div_b = D'(b);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        if (lit) begin
            chk("lat", edges, e_edges);
            chk("q", div_q, e_q);
            chk("r", div_r, e_r);
            chk("dbz", div_by_zero, e_dbz);
        end
    endtask

    initial begin
        int edges;
        #1;
        rst_n = 1'b0;
        #20;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", div_q, 0);
        chk("rst_r", div_r, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_err", check_err, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        run_op(200, 7, 1, 8, 28, 4, 0);
        run_op(255, 15, 1, 8, 17, 0, 0);
        run_op(3, 9, 1, 8, 0, 3, 0);
        run_op(13, 0, 1, 0, 255, 0, 1);
        run_op(100, 10, 1, 8, 10, 0, 0);
        run_op(0, 1, 1, 8, 0, 0, 0);
        run_op(255, 1, 1, 8, 255, 0, 0);
        run_op(254, 15, 1, 8, 16, 14, 0);

        // start during CALC cycle 3 must be ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        div_a = 8'd200;
        div_b = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b1;
        div_a = 8'd50;
        div_b = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        chk("ign_lat", edges, 5);
        chk("ign_q", div_q, 28);
        chk("ign_r", div_r, 4);

        // start held in the DONE cycle: next result 9 cycles later
        #1;
        start = 1'b1;
        div_a = 8'd255;
        div_b = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        chk("b2b_gap", edges + 1, 9);
        chk("b2b_q", div_q, 17);
        chk("b2b_r", div_r, 0);

        // reset during CALC cycle 4
        @(posedge clk);
        #1;
        start = 1'b1;
        div_a = 8'd200;
        div_b = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", div_q, 0);
        chk("mid_rst_r", div_r, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_op(200, 7, 1, 8, 28, 4, 0);

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(a, b, 0, 0, 0, 0, 0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("final_err", check_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
